// File: rtl/mc_axi_lim_pkg.sv
// Shared reset values and counter/watchdog update helpers for the AXI
// transaction limiter.
package mc_axi_lim_pkg;

    localparam logic READY_RST = 1'b1;
    localparam logic VALID_RST = 1'b0;

    // Outstanding counter next value; a decrement at zero holds at zero.
    function automatic logic [31:0] cnt_next(
        input logic [31:0] cnt,
        input logic        inc,
        input logic        dec
    );
        logic [31:0] nxt;
        if (inc && !dec) begin
            nxt = cnt + 32'd1;
        end else if (dec && !inc && (cnt != 32'd0)) begin
            nxt = cnt - 32'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Watchdog timer next value, saturating at the limit.
    function automatic logic [31:0] tmr_next(
        input logic [31:0] tmr,
        input logic        clr,
        input logic [31:0] limit
    );
        logic [31:0] nxt;
        if (clr) begin
            nxt = 32'd0;
        end else if (tmr >= limit) begin
            nxt = limit;
        end else begin
            nxt = tmr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mc_axi_txn_limiter_chk.sv
// Invariant checks for the outstanding counters of the transaction limiter.
module mc_axi_txn_limiter_chk #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] wr_cnt,
    input logic [CNT_W-1:0] rd_cnt
);

    wr_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        wr_cnt <= CNT_W'(MAX_OUTSTANDING));

    rd_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        rd_cnt <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/mc_axi_txn_limiter_skid.sv
// Two-entry address-channel skid buffer with registered ready/valid and an
// external launch enable that only gates the rising edge of m_valid.
module axi_skid_buf
    import mc_axi_lim_pkg::*;
#(
    parameter int W = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         launch_en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_payload,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_payload
);

    logic         head_full_q, head_full_d;
    logic         tail_full_q, tail_full_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         push_s, pop_s;

    // Next-state: pop shifts the tail forward, push fills the first free slot.
    always_comb begin
        push_s      = s_valid && ready_q;
        pop_s       = valid_q && m_ready;
        head_full_d = head_full_q;
        tail_full_d = tail_full_q;
        head_d      = head_q;
        tail_d      = tail_q;

        if (pop_s) begin
            head_full_d = tail_full_q;
            head_d      = tail_q;
            tail_full_d = 1'b0;
        end else begin
            head_full_d = head_full_q;
            head_d      = head_q;
        end

        if (push_s) begin
            if (!head_full_d) begin
                head_full_d = 1'b1;
                head_d      = s_payload;
            end else begin
                tail_full_d = 1'b1;
                tail_d      = s_payload;
            end
        end else begin
            tail_d = tail_d;
        end

        ready_d = !(head_full_d && tail_full_d);

        // A presented request is held regardless of the launch gate.
        if (valid_q && !m_ready) begin
            valid_d = 1'b1;
        end else begin
            valid_d = head_full_d && launch_en;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_full_q <= 1'b0;
            tail_full_q <= 1'b0;
            head_q      <= {W{1'b0}};
            tail_q      <= {W{1'b0}};
            ready_q     <= READY_RST;
            valid_q     <= VALID_RST;
        end else begin
            head_full_q <= head_full_d;
            tail_full_q <= tail_full_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign s_ready   = ready_q;
    assign m_valid   = valid_q;
    assign m_payload = head_q;

endmodule

// File: rtl/mc_axi_txn_limiter.sv
// AXI4 AW/AR admission limiter: calibration gate, per-direction outstanding
// caps, registered address channels and response watchdogs.
module mc_axi_txn_limiter
    import mc_axi_lim_pkg::*;
#(
    parameter int AX_W            = 80,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int TIMEOUT         = 65535,
    parameter int TMR_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phy_init_done,
    input  logic             s_aw_valid,
    output logic             s_aw_ready,
    input  logic [AX_W-1:0]  s_aw_payload,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    output logic [AX_W-1:0]  m_aw_payload,
    input  logic             s_ar_valid,
    output logic             s_ar_ready,
    input  logic [AX_W-1:0]  s_ar_payload,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    output logic [AX_W-1:0]  m_ar_payload,
    input  logic             b_valid,
    input  logic             b_ready,
    input  logic             r_valid,
    input  logic             r_ready,
    input  logic             r_last,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             wr_timeout,
    output logic             rd_timeout,
    output logic             protocol_err
);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [TMR_W-1:0] wr_tmr_q, wr_tmr_d;
    logic [TMR_W-1:0] rd_tmr_q, rd_tmr_d;
    logic             wr_to_q, wr_to_d;
    logic             rd_to_q, rd_to_d;
    logic             perr_q, perr_d;
    logic             aw_hs_s, ar_hs_s, b_hs_s, r_hs_s, r_last_hs_s;
    logic             aw_launch_en_s, ar_launch_en_s;

    // Counters, watchdogs and launch gates. The gate looks at next-cycle
    // counts, so a decrement re-opens launching only from the following cycle.
    always_comb begin
        aw_hs_s     = m_aw_valid && m_aw_ready;
        ar_hs_s     = m_ar_valid && m_ar_ready;
        b_hs_s      = b_valid && b_ready;
        r_hs_s      = r_valid && r_ready;
        r_last_hs_s = r_hs_s && r_last;

        wr_cnt_d = CNT_W'(cnt_next(32'(wr_cnt_q), aw_hs_s, b_hs_s));
        rd_cnt_d = CNT_W'(cnt_next(32'(rd_cnt_q), ar_hs_s, r_last_hs_s));

        wr_tmr_d = TMR_W'(tmr_next(32'(wr_tmr_q),
                                   (wr_cnt_q == {CNT_W{1'b0}}) || b_hs_s,
                                   32'(TIMEOUT)));
        rd_tmr_d = TMR_W'(tmr_next(32'(rd_tmr_q),
                                   (rd_cnt_q == {CNT_W{1'b0}}) || r_hs_s,
                                   32'(TIMEOUT)));

        wr_to_d = wr_to_q || (wr_tmr_d == TMR_W'(TIMEOUT));
        rd_to_d = rd_to_q || (rd_tmr_d == TMR_W'(TIMEOUT));

        perr_d = perr_q
               || (b_hs_s && (wr_cnt_q == {CNT_W{1'b0}}))
               || (r_last_hs_s && (rd_cnt_q == {CNT_W{1'b0}}));

        aw_launch_en_s = phy_init_done && (wr_cnt_d < CNT_W'(MAX_OUTSTANDING));
        ar_launch_en_s = phy_init_done && (rd_cnt_d < CNT_W'(MAX_OUTSTANDING));
    end

    // Counter, timer and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= {CNT_W{1'b0}};
            rd_cnt_q <= {CNT_W{1'b0}};
            wr_tmr_q <= {TMR_W{1'b0}};
            rd_tmr_q <= {TMR_W{1'b0}};
            wr_to_q  <= 1'b0;
            rd_to_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_tmr_q <= wr_tmr_d;
            rd_tmr_q <= rd_tmr_d;
            wr_to_q  <= wr_to_d;
            rd_to_q  <= rd_to_d;
            perr_q   <= perr_d;
        end
    end

    axi_skid_buf #(.W(AX_W)) u_aw_buf (
        .clk       (clk),
        .rst       (rst),
        .launch_en (aw_launch_en_s),
        .s_valid   (s_aw_valid),
        .s_ready   (s_aw_ready),
        .s_payload (s_aw_payload),
        .m_valid   (m_aw_valid),
        .m_ready   (m_aw_ready),
        .m_payload (m_aw_payload)
    );

    axi_skid_buf #(.W(AX_W)) u_ar_buf (
        .clk       (clk),
        .rst       (rst),
        .launch_en (ar_launch_en_s),
        .s_valid   (s_ar_valid),
        .s_ready   (s_ar_ready),
        .s_payload (s_ar_payload),
        .m_valid   (m_ar_valid),
        .m_ready   (m_ar_ready),
        .m_payload (m_ar_payload)
    );

    mc_axi_txn_limiter_chk #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .wr_cnt (wr_cnt_q),
        .rd_cnt (rd_cnt_q)
    );

    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;
    assign wr_timeout     = wr_to_q;
    assign rd_timeout     = rd_to_q;
    assign protocol_err   = perr_q;

endmodule

// File: tb/tb_mc_axi_txn_limiter.sv
// Bench for mc_axi_txn_limiter (MAX_OUTSTANDING=4, TIMEOUT=100): a per-cycle
// vector table for the write channel, hand sequences and a payload scoreboard.
module tb_mc_axi_txn_limiter;

    localparam int AX_W  = 80;
    localparam int MAXO  = 4;
    localparam int CNT_W = 3;
    localparam int TMO   = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             phy_init_done;
    logic             s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic             s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic [AX_W-1:0]  s_aw_payload, m_aw_payload, s_ar_payload, m_ar_payload;
    logic             b_valid, b_ready, r_valid, r_ready, r_last;
    logic [CNT_W-1:0] wr_outstanding, rd_outstanding;
    logic             wr_timeout, rd_timeout, protocol_err;

    int checks   = 0;
    int failures = 0;
    int aw_seq   = 0;
    int ar_seq   = 0;
    int ar_issued = 0;

    logic [AX_W-1:0] aw_q[$];
    logic [AX_W-1:0] ar_q[$];
    logic [AX_W-1:0] aw_e, ar_e;

    typedef struct packed {
        logic       phy;
        logic       aw_v;
        logic       b_v;
        logic       exp_srdy;
        logic       exp_mv;
        logic [2:0] exp_cnt;
        logic       exp_perr;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    mc_axi_txn_limiter #(
        .AX_W(AX_W), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W),
        .TIMEOUT(TMO), .TMR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .phy_init_done(phy_init_done),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_payload(s_aw_payload),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_payload(m_aw_payload),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_payload(s_ar_payload),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_payload(m_ar_payload),
        .b_valid(b_valid), .b_ready(b_ready),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .wr_timeout(wr_timeout), .rd_timeout(rd_timeout), .protocol_err(protocol_err)
    );

    function automatic logic [AX_W-1:0] mk_pay(input logic [7:0] tag, input int n);
        return {tag, 40'h5AC3960F11, 32'(n)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_pay(input string name, input logic [AX_W-1:0] act,
                           input logic [AX_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: note handshakes before the edge, then refresh upstream payloads.
    task automatic step();
        logic aw_acc, ar_acc, ar_iss;
        aw_acc = s_aw_valid && s_aw_ready;
        ar_acc = s_ar_valid && s_ar_ready;
        ar_iss = m_ar_valid && m_ar_ready;
        @(posedge clk);
        #1;
        if (aw_acc) aw_seq++;
        if (ar_acc) ar_seq++;
        if (ar_iss) ar_issued++;
        s_aw_payload = mk_pay(8'hA0, aw_seq);
        s_ar_payload = mk_pay(8'hB0, ar_seq);
    endtask

    task automatic wait_aw_accepts(input int n);
        int target;
        int g;
        target = aw_seq + n;
        g = 0;
        while (aw_seq < target && g < 30) begin
            step();
            g++;
        end
        chk("aw_accept_wait", int'(aw_seq >= target), 1);
    endtask

    // Scoreboard: expected payloads queued on upstream accept, checked on issue.
    always @(negedge clk) begin
        if (rst) begin
            aw_q.delete();
            ar_q.delete();
        end else begin
            if (m_aw_valid && m_aw_ready) begin
                if (aw_q.size() == 0) begin
                    chk("aw_sb_underrun", 1, 0);
                end else begin
                    aw_e = aw_q.pop_front();
                    chk_pay("aw_payload_order", m_aw_payload, aw_e);
                end
            end
            if (m_ar_valid && m_ar_ready) begin
                if (ar_q.size() == 0) begin
                    chk("ar_sb_underrun", 1, 0);
                end else begin
                    ar_e = ar_q.pop_front();
                    chk_pay("ar_payload_order", m_ar_payload, ar_e);
                end
            end
            if (s_aw_valid && s_aw_ready) aw_q.push_back(s_aw_payload);
            if (s_ar_valid && s_ar_ready) ar_q.push_back(s_ar_payload);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int g;
        logic [AX_W-1:0] exp_pay;

        //             phy   aw_v  b_v   srdy  mv    cnt   perr
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};

        rst = 1'b1; phy_init_done = 1'b0;
        s_aw_valid = 1'b0; m_aw_ready = 1'b0; s_ar_valid = 1'b0; m_ar_ready = 1'b0;
        s_aw_payload = mk_pay(8'hA0, 0); s_ar_payload = mk_pay(8'hB0, 0);
        b_valid = 1'b0; b_ready = 1'b1; r_valid = 1'b0; r_ready = 1'b1; r_last = 1'b0;
        repeat (3) step();

        chk("rst_s_aw_ready", int'(s_aw_ready), 1);
        chk("rst_s_ar_ready", int'(s_ar_ready), 1);
        chk("rst_m_aw_valid", int'(m_aw_valid), 0);
        chk("rst_m_ar_valid", int'(m_ar_valid), 0);
        chk("rst_wr_outstanding", int'(wr_outstanding), 0);
        chk("rst_rd_outstanding", int'(rd_outstanding), 0);
        chk("rst_flags", int'({wr_timeout, rd_timeout, protocol_err}), 0);
        chk_pay("rst_m_aw_payload", m_aw_payload, {AX_W{1'b0}});
        rst = 1'b0;

        // Calibration gate, ordered issue, simultaneous inc/dec and underflow.
        m_aw_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            phy_init_done = tbl[i].phy;
            s_aw_valid    = tbl[i].aw_v;
            b_valid       = tbl[i].b_v;
            step();
            chk($sformatf("tbl%0d_s_aw_ready", i), int'(s_aw_ready), int'(tbl[i].exp_srdy));
            chk($sformatf("tbl%0d_m_aw_valid", i), int'(m_aw_valid), int'(tbl[i].exp_mv));
            chk($sformatf("tbl%0d_wr_outstanding", i), int'(wr_outstanding), int'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_protocol_err", i), int'(protocol_err), int'(tbl[i].exp_perr));
        end
        s_aw_valid = 1'b0; b_valid = 1'b0; m_aw_ready = 1'b0;

        // Read limit: six requests, only four may be in flight.
        phy_init_done = 1'b1; m_ar_ready = 1'b1; s_ar_valid = 1'b1;
        g = 0;
        while (ar_seq < 6 && g < 40) begin
            step();
            g++;
        end
        chk("ar_accept_wait", ar_seq, 6);
        s_ar_valid = 1'b0;
        repeat (3) step();
        chk("lim_rd_outstanding", int'(rd_outstanding), 4);
        chk("lim_ar_issued", ar_issued, 4);
        chk("lim_m_ar_valid", int'(m_ar_valid), 0);
        chk("lim_s_ar_ready_full", int'(s_ar_ready), 0);

        r_valid = 1'b1; r_last = 1'b1;
        step();
        r_valid = 1'b0; r_last = 1'b0;
        chk("lim_reopen_m_ar_valid", int'(m_ar_valid), 1);
        chk("lim_reopen_rd_outstanding", int'(rd_outstanding), 3);
        step();
        chk("lim_refill_rd_outstanding", int'(rd_outstanding), 4);
        chk("lim_refill_m_ar_valid", int'(m_ar_valid), 0);
        chk("lim_refill_s_ar_ready", int'(s_ar_ready), 1);
        r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        chk("lim_nonlast_rd_outstanding", int'(rd_outstanding), 4);
        chk("lim_nonlast_m_ar_valid", int'(m_ar_valid), 0);

        // Stability under backpressure while calibration drops.
        m_aw_ready = 1'b0; s_aw_valid = 1'b1;
        exp_pay = s_aw_payload;
        step();
        s_aw_valid = 1'b0;
        chk("stab_first_valid", int'(m_aw_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) phy_init_done = 1'b0;
            step();
            chk($sformatf("stab%0d_m_aw_valid", i), int'(m_aw_valid), 1);
            chk_pay($sformatf("stab%0d_m_aw_payload", i), m_aw_payload, exp_pay);
        end
        m_aw_ready = 1'b1;
        step();
        chk("stab_done_m_aw_valid", int'(m_aw_valid), 0);
        chk("stab_done_wr_outstanding", int'(wr_outstanding), 1);

        // Write watchdog: flag exactly TIMEOUT cycles after the last clear.
        repeat (TMO - 1) step();
        chk("wdog_before_limit", int'(wr_timeout), 0);
        step();
        chk("wdog_at_limit", int'(wr_timeout), 1);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        chk("wdog_b_wr_outstanding", int'(wr_outstanding), 0);
        chk("wdog_sticky", int'(wr_timeout), 1);
        chk("rd_wdog_set", int'(rd_timeout), 1);

        // Reset mid-flight: three outstanding writes and two buffered.
        phy_init_done = 1'b1; s_aw_valid = 1'b1;
        wait_aw_accepts(3);
        s_aw_valid = 1'b0;
        g = 0;
        while (wr_outstanding != 3'd3 && g < 10) begin
            step();
            g++;
        end
        chk("mid_wr_outstanding", int'(wr_outstanding), 3);
        phy_init_done = 1'b0; s_aw_valid = 1'b1;
        wait_aw_accepts(2);
        s_aw_valid = 1'b0;
        step();
        chk("mid_s_aw_ready_full", int'(s_aw_ready), 0);
        chk("mid_m_aw_valid_gated", int'(m_aw_valid), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_counts", int'({wr_outstanding, rd_outstanding}), 0);
        chk("mrst_m_valids", int'({m_aw_valid, m_ar_valid}), 0);
        chk("mrst_s_readys", int'({s_aw_ready, s_ar_ready}), 3);
        chk("mrst_flags", int'({wr_timeout, rd_timeout, protocol_err}), 0);
        phy_init_done = 1'b1;
        repeat (3) step();
        chk("mrst_no_stale_issue", int'({m_aw_valid, m_ar_valid}), 0);

        // Response one cycle before the limit: no flag.
        s_aw_valid = 1'b1;
        step();
        s_aw_valid = 1'b0;
        g = 0;
        while (wr_outstanding != 3'd1 && g < 10) begin
            step();
            g++;
        end
        chk("nf_wr_outstanding", int'(wr_outstanding), 1);
        repeat (TMO - 2) step();
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        chk("nf_b_wr_outstanding", int'(wr_outstanding), 0);
        chk("nf_wr_timeout", int'(wr_timeout), 0);
        repeat (20) step();
        chk("nf_wr_timeout_later", int'(wr_timeout), 0);
        chk("aw_sb_drained", aw_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_axi_txn_limiter.md
Name: mc_axi_txn_limiter

Overview:
- Sits in the memory-controller clock domain, between the NoC-to-AXI4 bridge master port and the DDR4 controller AXI4 slave port.
- Holds AW/AR requests until PHY calibration completes.
- Caps outstanding write and read transactions independently.
- Registers the address channels, and flags stalled responses with a watchdog.
- W, B and R data/payload wires bypass the block; only their handshakes are snooped.

Parameters:
- AX_W, 80: width of the opaque packed address-channel payload (id, addr, len, size, burst, lock, cache, prot, qos).
- MAX_OUTSTANDING, 16: maximum in-flight transactions per direction; must be at least 1.
- CNT_W, $clog2(MAX_OUTSTANDING+1): derived counter width.
- TIMEOUT, 65535: idle cycles with outstanding>0 and no response before the timeout flag sets.
- TMR_W, 16: watchdog timer width; must satisfy TIMEOUT < 2^TMR_W.

Ports:
- clk  in  1  memory-controller clock.
- rst  in  1  reset, synchronous, active-high.
- phy_init_done  in  1  DDR4 calibration complete.
- s_aw_valid  in  1  / s_aw_ready  out  1 / s_aw_payload  in  AX_W  upstream write address.
- m_aw_valid  out  1 / m_aw_ready  in  1 / m_aw_payload  out  AX_W  downstream write address.
- s_ar_valid  in  1 / s_ar_ready  out  1 / s_ar_payload  in  AX_W  upstream read address.
- m_ar_valid  out  1 / m_ar_ready  in  1 / m_ar_payload  out  AX_W  downstream read address.
- b_valid, b_ready  in  1 each  snooped B handshake.
- r_valid, r_ready, r_last  in  1 each  snooped R handshake.
- wr_outstanding, rd_outstanding  out  CNT_W  live counts.
- wr_timeout, rd_timeout  out  1  sticky watchdog flags.
- protocol_err  out  1  sticky; set on a response while the matching count is 0.

Behaviour:
- Interface: one clock, clk. rst is synchronous, active-high.
- Reset values: all outputs 0 except s_aw_ready=1 and s_ar_ready=1. Buffers are emptied, counters and timers cleared.
- A rst assertion mid-operation discards buffered requests with no downstream handshake, and clears the sticky flags.
- AW and AR use identical, independent channel logic:
  - 2-entry skid buffer; s_x_ready is a registered output, =1 while the buffer has a free entry.
  - Upstream handshake in cycle N makes the entry presentable at m_x_valid in cycle N+1 at the earliest.
  - Sustained throughput is 1 transaction per cycle when not limited.
  - Launch condition: m_x_valid rises only when the buffer is non-empty, phy_init_done=1, and count < MAX_OUTSTANDING, all sampled in the same cycle.
  - Once m_x_valid=1, it and m_x_payload hold stable until m_x_ready=1, even if phy_init_done drops or the count changes.
  - Payload ordering is FIFO; payload bits are never modified.
- Write counter:
  - +1 on m_aw_valid && m_aw_ready.
  - −1 on b_valid && b_ready.
  - Both in the same cycle: net 0.
- Read counter:
  - +1 on m_ar_valid && m_ar_ready.
  - −1 on r_valid && r_ready && r_last.
  - Both in the same cycle: net 0.
- Underflow: a decrement at count 0 holds the count at 0 and sets protocol_err.
- Overflow is impossible by construction; an assertion checks count ≤ MAX_OUTSTANDING.
- Gate re-opens on decrement: a decrement from MAX in cycle N allows a launch in cycle N+1, not in cycle N (no combinational bypass).
- Watchdog, per direction:
  - Timer clears when count = 0 or a response handshake occurs; otherwise it increments.
  - Timer saturates at TIMEOUT. On reaching TIMEOUT, x_timeout sets and stays set until rst.
  - Non-final R beats (r_last=0) also clear the read timer.
- Behaviour while phy_init_done=0: requests accumulate until both skid entries are full, then s_x_ready=0. No downstream valid is issued.

Decomposition:
- Package mc_axi_lim_pkg holds the reset values of ready and valid, and the counter/timer update helper function.
- One sub-module, axi_skid_buf (2-entry, AX_W-wide, registered ready, external launch-enable input), instantiated twice for AW and AR.
- Counters, watchdogs and error logic live in the top module.

Test Plan:
- Calibration gate: phy_init_done=0, push 3 AW → 2 accepted, s_aw_ready=0, m_aw_valid=0. Raise phy_init_done → both issued in order on consecutive cycles, third accepted.
- Limit: MAX_OUTSTANDING=4, issue 6 AR with m_ar_ready=1 and no R → exactly 4 issued, rd_outstanding=4. One r_last beat in cycle N → 5th AR valid in cycle N+1, count returns to 4.
- Simultaneous events: AW handshake and B handshake in the same cycle with count=2 → count stays 2. A B handshake at count 0 → count 0, protocol_err=1.
- Stability: present AW, hold m_aw_ready=0 for 10 cycles while dropping phy_init_done → m_aw_valid and payload constant, handshake completes on ready.
- Watchdog: TIMEOUT=100, one write outstanding, no B → wr_timeout=1 exactly 100 cycles after the last clear. A B handshake at cycle 99 → no flag.
- Reset mid-flight: 2 buffered plus 3 outstanding, assert rst one cycle → all counts 0, m_*_valid=0, s_*_ready=1, flags cleared.
